// File: rtl/bp_output_delta_engine_if.sv
// Handshake and data bundle for the output-layer delta engine.
// The slave view belongs to the engine; the master view belongs to whatever feeds and drains it.
interface bp_output_delta_engine_if #(
    parameter int DATA_WIDTH = 16,
    parameter int IDX_WIDTH  = 8
);
    logic                  i_valid;
    logic                  o_ready;
    logic [DATA_WIDTH-1:0] i_data_expected;
    logic [DATA_WIDTH-1:0] i_data_node;
    logic [IDX_WIDTH-1:0]  i_action;
    logic [1:0]            i_mode;
    logic                  i_mask_en;
    logic                  o_valid;
    logic                  i_ready;
    logic [DATA_WIDTH-1:0] o_delta;
    logic [IDX_WIDTH-1:0]  o_index;
    logic                  o_last;
    logic                  o_busy;
    logic                  o_err;

    modport slave (
        input  i_valid, i_data_expected, i_data_node, i_action, i_mode, i_mask_en, i_ready,
        output o_ready, o_valid, o_delta, o_index, o_last, o_busy, o_err
    );

    modport master (
        output i_valid, i_data_expected, i_data_node, i_action, i_mode, i_mask_en, i_ready,
        input  o_ready, o_valid, o_delta, o_index, o_last, o_busy, o_err
    );
endinterface

// File: rtl/bp_output_delta_engine.sv
// Computes per-node output deltas (node - expected) for one frame, buffers them,
// then streams them out in index order once the whole frame has been collected.
module bp_output_delta_engine #(
    parameter int                    DATA_WIDTH = 16,
    parameter int                    NUM_NODES  = 3,
    parameter int                    IDX_WIDTH  = 8,
    parameter logic [DATA_WIDTH-1:0] CLIP_VALUE = 16'h0100
) (
    input logic                     clk,
    input logic                     rst_n,
    bp_output_delta_engine_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DRAIN
    } state_t;

    localparam int                        BUF_AW     = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1;
    localparam logic [IDX_WIDTH-1:0]      LAST_IDX   = IDX_WIDTH'(NUM_NODES - 1);
    localparam logic [IDX_WIDTH:0]        NODE_COUNT = (IDX_WIDTH + 1)'(NUM_NODES);
    localparam logic signed [DATA_WIDTH-1:0] MAX_VAL  = {1'b0, {(DATA_WIDTH - 1){1'b1}}};
    localparam logic signed [DATA_WIDTH-1:0] MIN_VAL  = {1'b1, {(DATA_WIDTH - 1){1'b0}}};
    localparam logic signed [DATA_WIDTH-1:0] POS_CLIP = CLIP_VALUE;
    localparam logic signed [DATA_WIDTH-1:0] NEG_CLIP = ~CLIP_VALUE + 1'b1;

    state_t                         r_state;
    logic [IDX_WIDTH-1:0]           r_nodeIdx;
    logic [IDX_WIDTH-1:0]           r_action;
    logic [1:0]                     r_mode;
    logic                           r_maskEn;
    logic                           r_oValid;
    logic                           r_oLast;
    logic                           r_busy;
    logic                           r_err;
    logic [DATA_WIDTH-1:0]          r_oDelta;
    logic [IDX_WIDTH-1:0]           r_oIndex;
    logic signed [DATA_WIDTH-1:0]   r_buf [NUM_NODES];

    logic                           w_ready;
    logic                           w_accept;
    logic                           w_firstSample;
    logic [1:0]                     w_mode;
    logic [IDX_WIDTH-1:0]           w_action;
    logic                           w_maskEn;
    logic signed [DATA_WIDTH-1:0]   w_node;
    logic signed [DATA_WIDTH-1:0]   w_exp;
    logic signed [DATA_WIDTH:0]     w_diff;
    logic                           w_overflow;
    logic signed [DATA_WIDTH-1:0]   w_satDelta;
    logic signed [DATA_WIDTH-1:0]   w_delta;
    logic                           w_illegalAction;
    logic                           w_errFlag;
    logic [IDX_WIDTH-1:0]           w_nextIdx;
    logic [BUF_AW-1:0]              w_wrAddr;
    logic [BUF_AW-1:0]              w_rdAddr;

    assign w_ready       = (r_state != DRAIN);
    assign w_accept      = bus.i_valid & w_ready;
    assign w_firstSample = (r_state == IDLE);

    // Frame controls are live on the first sample and held from the capture registers afterwards.
    assign w_mode   = w_firstSample ? bus.i_mode    : r_mode;
    assign w_action = w_firstSample ? bus.i_action  : r_action;
    assign w_maskEn = w_firstSample ? bus.i_mask_en : r_maskEn;

    assign w_node     = bus.i_data_node;
    assign w_exp      = bus.i_data_expected;
    assign w_diff     = $signed({w_node[DATA_WIDTH-1], w_node}) - $signed({w_exp[DATA_WIDTH-1], w_exp});
    assign w_overflow = w_diff[DATA_WIDTH] ^ w_diff[DATA_WIDTH-1];
    assign w_satDelta = w_overflow ? (w_diff[DATA_WIDTH] ? MIN_VAL : MAX_VAL) : w_diff[DATA_WIDTH-1:0];

    assign w_illegalAction = w_maskEn && ({1'b0, w_action} >= NODE_COUNT);
    assign w_errFlag       = w_overflow | w_illegalAction;

    assign w_nextIdx = r_oIndex + 1'b1;
    assign w_wrAddr  = r_nodeIdx[BUF_AW-1:0];
    assign w_rdAddr  = w_nextIdx[BUF_AW-1:0];

    always_comb begin
        w_delta = w_satDelta;
        case (w_mode)
            2'd1: begin
                if (w_node[DATA_WIDTH-1] || (w_node == '0)) begin
                    w_delta = '0;
                end
            end
            2'd2: begin
                if (w_satDelta > POS_CLIP) begin
                    w_delta = POS_CLIP;
                end else if (w_satDelta < NEG_CLIP) begin
                    w_delta = NEG_CLIP;
                end
            end
            default: begin
                w_delta = w_satDelta;
            end
        endcase
        if ((w_maskEn && (r_nodeIdx != w_action)) || w_illegalAction) begin
            w_delta = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_buf[w_wrAddr] <= w_delta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_nodeIdx <= '0;
            r_action  <= '0;
            r_mode    <= '0;
            r_maskEn  <= 1'b0;
            r_oValid  <= 1'b0;
            r_oLast   <= 1'b0;
            r_busy    <= 1'b0;
            r_err     <= 1'b0;
            r_oDelta  <= '0;
            r_oIndex  <= '0;
        end else begin
            case (r_state)
                IDLE, LOAD: begin
                    if (w_accept) begin
                        r_busy <= 1'b1;
                        if (w_firstSample) begin
                            r_mode   <= bus.i_mode;
                            r_action <= bus.i_action;
                            r_maskEn <= bus.i_mask_en;
                            r_err    <= w_errFlag;
                        end else begin
                            r_err <= r_err | w_errFlag;
                        end
                        // Entry 0 may be written on this same edge when the frame has a single node.
                        if (r_nodeIdx == LAST_IDX) begin
                            r_state   <= DRAIN;
                            r_nodeIdx <= '0;
                            r_oValid  <= 1'b1;
                            r_oIndex  <= '0;
                            r_oDelta  <= (r_nodeIdx == '0) ? w_delta : r_buf[0];
                            r_oLast   <= (LAST_IDX == '0);
                        end else begin
                            r_state   <= LOAD;
                            r_nodeIdx <= r_nodeIdx + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (r_oValid && bus.i_ready) begin
                        if (r_oLast) begin
                            r_state  <= IDLE;
                            r_oValid <= 1'b0;
                            r_oLast  <= 1'b0;
                            r_busy   <= 1'b0;
                        end else begin
                            r_oIndex <= w_nextIdx;
                            r_oDelta <= r_buf[w_rdAddr];
                            r_oLast  <= (w_nextIdx == LAST_IDX);
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.o_ready = w_ready;
    assign bus.o_valid = r_oValid;
    assign bus.o_delta = r_oDelta;
    assign bus.o_index = r_oIndex;
    assign bus.o_last  = r_oLast;
    assign bus.o_busy  = r_busy;
    assign bus.o_err   = r_err;

endmodule

// File: tb/tb_bp_output_delta_engine.sv
// Frame-level bench for the delta engine: a table of frames with hand-computed deltas
// feeds a scoreboard queue that is drained against the output stream.
module tb_bp_output_delta_engine;

    localparam int DW = 16;
    localparam int NN = 3;
    localparam int IW = 8;
    localparam int NUM_FRAMES = 8;

    typedef struct {
        logic [1:0]         mode;
        logic               maskEn;
        logic [IW-1:0]      action;
        logic [NN-1:0][DW-1:0] node;
        logic [NN-1:0][DW-1:0] expVal;
        logic [NN-1:0][DW-1:0] expDelta;
        logic               expErr;
    } frame_t;

    typedef struct packed {
        logic [DW-1:0] delta;
        logic [IW-1:0] index;
        logic          last;
    } expect_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   nChecks = 0;
    int   nErrors = 0;

    frame_t  vectors [NUM_FRAMES];
    expect_t expQ [$];

    always #5 clk = ~clk;

    bp_output_delta_engine_if #(.DATA_WIDTH(DW), .IDX_WIDTH(IW)) bus ();

    bp_output_delta_engine #(
        .DATA_WIDTH(DW),
        .NUM_NODES (NN),
        .IDX_WIDTH (IW),
        .CLIP_VALUE(16'h0100)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nErrors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic setFrame(input int f, input logic [1:0] mode, input logic maskEn, input logic [IW-1:0] action,
                            input logic [DW-1:0] n0, input logic [DW-1:0] e0, input logic [DW-1:0] d0,
                            input logic [DW-1:0] n1, input logic [DW-1:0] e1, input logic [DW-1:0] d1,
                            input logic [DW-1:0] n2, input logic [DW-1:0] e2, input logic [DW-1:0] d2,
                            input logic expErr);
        vectors[f].mode     = mode;
        vectors[f].maskEn   = maskEn;
        vectors[f].action   = action;
        vectors[f].node     = {n2, n1, n0};
        vectors[f].expVal   = {e2, e1, e0};
        vectors[f].expDelta = {d2, d1, d0};
        vectors[f].expErr   = expErr;
    endtask

    // Drives the first `count` samples of a frame; later samples carry decoy control fields.
    task automatic applyStimulus(input int f, input int count);
        expect_t item;
        for (int i = 0; i < count; i++) begin
            @(negedge clk);
            if (i == 1) begin
                checkOutput("busyInLoad", {31'd0, bus.o_busy}, 32'd1);
                if (!vectors[f].expErr) begin
                    checkOutput("errClearedOnFirstAccept", {31'd0, bus.o_err}, 32'd0);
                end
            end
            checkOutput("readyBeforeAccept", {31'd0, bus.o_ready}, 32'd1);
            bus.i_valid         = 1'b1;
            bus.i_data_node     = vectors[f].node[i];
            bus.i_data_expected = vectors[f].expVal[i];
            bus.i_mode          = (i == 0) ? vectors[f].mode   : ~vectors[f].mode;
            bus.i_mask_en       = (i == 0) ? vectors[f].maskEn : ~vectors[f].maskEn;
            bus.i_action        = (i == 0) ? vectors[f].action : (vectors[f].action ^ 8'h01);
            item.delta = vectors[f].expDelta[i];
            item.index = IW'(i);
            item.last  = (i == NN - 1);
            expQ.push_back(item);
        end
    endtask

    // Consumes the output stream; cycles stallFrom..stallFrom+3 hold i_ready low and push junk inputs.
    task automatic drainFrame(input int f, input int stallFrom);
        expect_t item;
        int      cycles = 0;
        bit      first = 1'b1;
        bit      stall;
        while (expQ.size() > 0 && cycles < 50) begin
            @(negedge clk);
            cycles++;
            stall = (stallFrom > 0) && (cycles >= stallFrom) && (cycles < stallFrom + 4);
            if (first) begin
                checkOutput("firstValidLatency", {31'd0, bus.o_valid}, 32'd1);
                checkOutput("frameErr", {31'd0, bus.o_err}, {31'd0, vectors[f].expErr});
                first = 1'b0;
            end
            if (stall) begin
                bus.i_ready         = 1'b0;
                bus.i_valid         = 1'b1;
                bus.i_data_node     = 16'h1234;
                bus.i_data_expected = 16'h0042;
                item = expQ[0];
                checkOutput("stallHold", {5'd0, bus.o_valid, bus.o_delta, bus.o_index, bus.o_last},
                            {5'd0, 1'b1, item.delta, item.index, item.last});
                checkOutput("readyLowInDrain", {31'd0, bus.o_ready}, 32'd0);
            end else begin
                bus.i_ready = 1'b1;
                bus.i_valid = 1'b0;
                if (bus.o_valid) begin
                    item = expQ.pop_front();
                    checkOutput($sformatf("delta[f%0d i%0d]", f, item.index), {16'd0, bus.o_delta}, {16'd0, item.delta});
                    checkOutput("index", {24'd0, bus.o_index}, {24'd0, item.index});
                    checkOutput("last", {31'd0, bus.o_last}, {31'd0, item.last});
                end
            end
        end
        if (expQ.size() > 0) begin
            checkOutput("drainTimeout", expQ.size(), 32'd0);
            expQ.delete();
        end
        @(negedge clk);
        bus.i_valid = 1'b0;
        checkOutput("validDropAfterLast", {31'd0, bus.o_valid}, 32'd0);
        checkOutput("busyDropAfterLast", {31'd0, bus.o_busy}, 32'd0);
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_outputs"},
                    {4'd0, bus.o_valid, bus.o_last, bus.o_busy, bus.o_err, bus.o_delta, bus.o_index},
                    32'd0);
        checkOutput({tag, "_ready"}, {31'd0, bus.o_ready}, 32'd1);
    endtask

    initial begin
        bit sawValid;
        bus.i_valid = 1'b0;
        bus.i_ready = 1'b1;
        bus.i_data_node = '0;
        bus.i_data_expected = '0;
        bus.i_action = '0;
        bus.i_mode = '0;
        bus.i_mask_en = 1'b0;

        setFrame(0, 2'd0, 1'b0, 8'd0, 16'h0300, 16'h0100, 16'h0200, 16'h0080, 16'h0100, 16'hFF80,
                 16'h0000, 16'h0000, 16'h0000, 1'b0);
        setFrame(1, 2'd2, 1'b0, 8'd0, 16'h0500, 16'h0100, 16'h0100, 16'h0000, 16'h0400, 16'hFF00,
                 16'h0050, 16'h0010, 16'h0040, 1'b0);
        setFrame(2, 2'd1, 1'b1, 8'd1, 16'hFF00, 16'h0100, 16'h0000, 16'h0200, 16'h0080, 16'h0180,
                 16'h0300, 16'h0100, 16'h0000, 1'b0);
        setFrame(3, 2'd0, 1'b0, 8'd0, 16'h7FFF, 16'h8000, 16'h7FFF, 16'h8000, 16'h7FFF, 16'h8000,
                 16'h0010, 16'h0020, 16'hFFF0, 1'b1);
        setFrame(4, 2'd0, 1'b1, 8'd5, 16'h0300, 16'h0100, 16'h0000, 16'h0100, 16'h0300, 16'h0000,
                 16'h7000, 16'h1000, 16'h0000, 1'b1);
        setFrame(5, 2'd3, 1'b0, 8'd0, 16'h1000, 16'h0800, 16'h0800, 16'h0100, 16'h0200, 16'hFF00,
                 16'h0000, 16'h0001, 16'hFFFF, 1'b0);
        setFrame(6, 2'd0, 1'b1, 8'd2, 16'h0001, 16'h0002, 16'h0000, 16'h0003, 16'h0001, 16'h0000,
                 16'h0005, 16'h0001, 16'h0004, 1'b0);
        setFrame(7, 2'd1, 1'b0, 8'd0, 16'hFF00, 16'h0100, 16'h0000, 16'h0001, 16'h0000, 16'h0001,
                 16'h0000, 16'h0100, 16'h0000, 1'b0);

        repeat (3) @(negedge clk);
        checkResetState("resetHeld");
        rst_n = 1'b1;
        @(negedge clk);
        checkResetState("afterRelease");

        for (int f = 0; f < NUM_FRAMES; f++) begin
            applyStimulus(f, NN);
            drainFrame(f, (f == 1) ? 2 : 0);
        end

        $display("[TB] mid-frame reset sequence");
        applyStimulus(5, 2);
        @(negedge clk);
        bus.i_valid = 1'b0;
        rst_n = 1'b0;
        expQ.delete();
        #1;
        checkResetState("asyncReset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        sawValid = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (bus.o_valid) sawValid = 1'b1;
        end
        checkOutput("noValidAfterReset", {31'd0, sawValid}, 32'd0);
        checkResetState("idleAfterReset");
        applyStimulus(0, NN);
        drainFrame(0, 0);

        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
